// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding, legal prescale
// bounds, parity-type constants and the 2-of-3 vote used by the majority sampler.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

    localparam int unsigned PRESCALE_MIN = 8;
    localparam int unsigned PRESCALE_MAX = 32;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_edge_bit_counter.sv
// Per-bit edge counter and data-bit counter with latched prescale; produces the
// sample, decision and bit-end strobes. Sample strobes widen under UART_RX_MAJORITY_EN.
module uart_rx_edge_bit_counter
    import uart_rx_pkg::*;
#(
    parameter int FRAME_WIDTH    = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      enable_i,
    input  logic                      clear_i,
    input  logic                      load_i,
    input  logic                      bit_inc_i,
    input  logic [PRESCALE_WIDTH-1:0] prescale_i,
    output logic                      sample_o,
    output logic                      decide_o,
    output logic                      bit_end_o,
    output logic                      bit_last_o
);
    localparam int BW = (FRAME_WIDTH > 1) ? $clog2(FRAME_WIDTH) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_WIDTH - 1);
    localparam logic [BW-1:0] BIT_ONE  = BW'(1);
    localparam logic [PRESCALE_WIDTH-1:0] ONE = PRESCALE_WIDTH'(1);

    logic [PRESCALE_WIDTH-1:0] prescale_q;
    logic [PRESCALE_WIDTH-1:0] half;
    logic [PRESCALE_WIDTH-1:0] edge_cnt_q, edge_cnt_d;
    logic [BW-1:0]             bit_cnt_q, bit_cnt_d;

    assign half       = prescale_q >> 1;
    assign bit_end_o  = (edge_cnt_q == (prescale_q - ONE));
    assign decide_o   = (edge_cnt_q == (half + ONE));
    assign bit_last_o = (bit_cnt_q == BIT_LAST);

`ifdef UART_RX_MAJORITY_EN
    assign sample_o = (edge_cnt_q == (half - ONE)) || (edge_cnt_q == half);
`else
    assign sample_o = (edge_cnt_q == half);
`endif

    always_comb begin
        edge_cnt_d = edge_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        if (clear_i) begin
            edge_cnt_d = '0;
            bit_cnt_d  = '0;
        end else if (enable_i) begin
            if (bit_end_o) begin
                edge_cnt_d = '0;
                if (bit_inc_i) begin
                    bit_cnt_d = bit_last_o ? '0 : bit_cnt_q + BIT_ONE;
                end
            end else begin
                edge_cnt_d = edge_cnt_q + ONE;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            prescale_q <= PRESCALE_WIDTH'(PRESCALE_MIN);
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
        end else begin
            if (load_i) begin
                prescale_q <= prescale_i;
            end
            edge_cnt_q <= edge_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_top.sv
// Oversampling UART receiver: start-bit glitch rejection, LSB-first deserializer,
// optional parity and stop-bit checks. UART_RX_MAJORITY_EN selects 2-of-3 bit voting.
//
// state     | meaning
// ST_IDLE   | line idle, waiting for a low sample (start edge 0)
// ST_START  | inside start bit, high at decision point means glitch
// ST_DATA   | shifting data bits in, LSB first
// ST_PARITY | capturing the parity bit
// ST_STOP   | capturing the stop bit, frame result issued after last edge
module uart_rx_top
    import uart_rx_pkg::*;
#(
    parameter int FRAME_WIDTH    = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      RX_IN,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    output logic [FRAME_WIDTH-1:0]    P_DATA,
    output logic                      Data_Valid,
    output logic                      par_err,
    output logic                      stp_err,
    output logic                      busy
);
    rx_state_e state_q, state_d;

    logic                   par_en_q, par_typ_q;
    logic [FRAME_WIDTH-1:0] shift_q, p_data_q;
    logic                   par_bit_q, stop_bit_q;
    logic                   data_valid_q, par_err_q, stp_err_q;
    logic                   sample, decide, bit_end, bit_last;
    logic                   start_det, bit_val, frame_end, frame_good, par_ok, clear_cnt;

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] samp_q;
    // third vote is the live line value at the decision edge
    assign bit_val = maj3(samp_q[1], samp_q[0], RX_IN);
`else
    logic samp_q;
    assign bit_val = samp_q;
`endif

    // busy covers the detection cycle itself, before the FSM has left IDLE
    assign start_det  = (state_q == ST_IDLE) && !RX_IN;
    assign busy       = (state_q != ST_IDLE) || start_det;
    assign frame_end  = (state_q == ST_STOP) && bit_end;
    assign clear_cnt  = (state_d == ST_IDLE);
    assign par_ok     = !par_en_q || (par_bit_q == ((^shift_q) ^ (par_typ_q == PAR_ODD)));
    assign frame_good = par_ok && stop_bit_q;

    uart_rx_edge_bit_counter #(
        .FRAME_WIDTH   (FRAME_WIDTH),
        .PRESCALE_WIDTH(PRESCALE_WIDTH)
    ) u_cnt (
        .CLK       (CLK),
        .RST       (RST),
        .enable_i  (busy),
        .clear_i   (clear_cnt),
        .load_i    (start_det),
        .bit_inc_i (state_q == ST_DATA),
        .prescale_i(Prescale),
        .sample_o  (sample),
        .decide_o  (decide),
        .bit_end_o (bit_end),
        .bit_last_o(bit_last)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (!RX_IN) state_d = ST_START;
            ST_START: begin
                if (decide && bit_val) begin
                    state_d = ST_IDLE;
                end else if (bit_end) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA:   if (bit_end && bit_last) state_d = par_en_q ? ST_PARITY : ST_STOP;
            ST_PARITY: if (bit_end) state_d = ST_STOP;
            ST_STOP:   if (bit_end) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            samp_q       <= '0;
            shift_q      <= '0;
            par_bit_q    <= 1'b0;
            stop_bit_q   <= 1'b0;
            p_data_q     <= '0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
        end else begin
            if (start_det) begin
                par_en_q  <= PAR_EN;
                par_typ_q <= PAR_TYP;
            end
            if (sample) begin
`ifdef UART_RX_MAJORITY_EN
                samp_q <= {samp_q[0], RX_IN};
`else
                samp_q <= RX_IN;
`endif
            end
            if (decide) begin
                case (state_q)
                    ST_DATA:   shift_q    <= {bit_val, shift_q[FRAME_WIDTH-1:1]};
                    ST_PARITY: par_bit_q  <= bit_val;
                    ST_STOP:   stop_bit_q <= bit_val;
                    default:   ;
                endcase
            end
            data_valid_q <= frame_end && frame_good;
            par_err_q    <= frame_end && !par_ok;
            stp_err_q    <= frame_end && !stop_bit_q;
            if (frame_end && frame_good) begin
                p_data_q <= shift_q;
            end
        end
    end

    assign P_DATA     = p_data_q;
    assign Data_Valid = data_valid_q;
    assign par_err    = par_err_q;
    assign stp_err    = stp_err_q;

endmodule

// File: tb/tb_uart_rx_top.sv
// Self-checking bench for uart_rx_top: a per-cycle timeline of line levels and
// expected outputs is built from frame-level rules, then replayed and compared.
module tb_uart_rx_top;
    localparam int FW   = 8;
    localparam int PW   = 6;
    localparam int MAXC = 24000;

    logic          CLK = 1'b0;
    logic          RST;
    logic          RX_IN;
    logic [PW-1:0] Prescale;
    logic          PAR_EN, PAR_TYP;
    logic [FW-1:0] P_DATA;
    logic          Data_Valid, par_err, stp_err, busy;

    uart_rx_top #(.FRAME_WIDTH(FW), .PRESCALE_WIDTH(PW)) dut (
        .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .Prescale(Prescale),
        .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .P_DATA(P_DATA),
        .Data_Valid(Data_Valid), .par_err(par_err), .stp_err(stp_err), .busy(busy)
    );

    always #5 CLK = ~CLK;

    logic          rx_a[MAXC], rst_a[MAXC], pen_a[MAXC], pt_a[MAXC];
    logic [PW-1:0] ps_a[MAXC];
    logic          eb_a[MAXC], edv_a[MAXC], epe_a[MAXC], ese_a[MAXC];
    logic [FW-1:0] epd_a[MAXC];

    typedef struct { int cyc; int sig; int val; } lit_t;
    lit_t lits[$];

    int            cur = 0;
    int            cyc = -1;
    int            checks = 0;
    int            errors = 0;
    logic [FW-1:0] m_pdata = '0;
    logic [FW-1:0] pend_data = '0;
    logic          pend_dv = 1'b0, pend_pe = 1'b0, pend_se = 1'b0;

    // one timeline slot; pending frame results land in the slot after the frame
    task automatic push(input logic rx, input logic rst, input logic bsy,
                        input logic [PW-1:0] ps, input logic pen, input logic pt);
        if (cur >= MAXC) return;
        rx_a[cur] = rx; rst_a[cur] = rst; ps_a[cur] = ps; pen_a[cur] = pen; pt_a[cur] = pt;
        if (rst) begin
            m_pdata = '0; pend_dv = 1'b0; pend_pe = 1'b0; pend_se = 1'b0;
        end
        if (pend_dv) m_pdata = pend_data;
        eb_a[cur]  = rst ? 1'b0 : bsy;
        edv_a[cur] = pend_dv;
        epe_a[cur] = pend_pe;
        ese_a[cur] = pend_se;
        epd_a[cur] = m_pdata;
        pend_dv = 1'b0; pend_pe = 1'b0; pend_se = 1'b0;
        cur++;
    endtask

    task automatic push_junk(input logic rx, input logic bsy);
        push(rx, 1'b0, bsy, PW'($urandom), 1'($urandom), 1'($urandom));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) push_junk(1'b1, 1'b0);
    endtask

    task automatic reset_cycles(input int n);
        for (int i = 0; i < n; i++) push(1'b1, 1'b1, 1'b0, PW'($urandom), 1'b0, 1'b0);
    endtask

    task automatic send_frame(input int p, input logic pen, input logic pt,
                              input logic [FW-1:0] d, input logic par_bad,
                              input logic stop_v, input int flip_at, input int cut_at,
                              output int start);
        int   f;
        int   bi;
        logic v;
        logic pbit;
        f     = FW + 2 + int'(pen);
        pbit  = (^d) ^ pt ^ par_bad;
        start = cur;
        for (int k = 0; k < f * p; k++) begin
            if (k == cut_at) return;
            bi = k / p;
            if (bi == 0)                   v = 1'b0;
            else if (bi <= FW)             v = d[bi-1];
            else if (pen && bi == FW + 1)  v = pbit;
            else                           v = stop_v;
            if (k == flip_at) v = ~v;
            if (k == 0) push(v, 1'b0, 1'b1, PW'(p), pen, pt);
            else        push_junk(v, 1'b1);
        end
        pend_dv   = (!pen || !par_bad) && stop_v;
        pend_pe   = pen && par_bad;
        pend_se   = !stop_v;
        pend_data = d;
    endtask

    task automatic glitch(input int p, input int lowlen, output int start);
        start = cur;
        for (int k = 0; k <= p / 2 + 2; k++) begin
            if (k == 0) push(1'b0, 1'b0, 1'b1, PW'(p), 1'($urandom), 1'($urandom));
            else        push_junk((k < lowlen) ? 1'b0 : 1'b1, k <= p / 2 + 1);
        end
    endtask

    function automatic string sig_name(input int s);
        case (s)
            0:       return "lit_P_DATA";
            1:       return "lit_Data_Valid";
            2:       return "lit_par_err";
            3:       return "lit_stp_err";
            default: return "lit_busy";
        endcase
    endfunction

    function automatic logic [31:0] sig_val(input int s);
        case (s)
            0:       return 32'(P_DATA);
            1:       return 32'(Data_Valid);
            2:       return 32'(par_err);
            3:       return 32'(stp_err);
            default: return 32'(busy);
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        #2;
        if (cyc >= 0) begin
            chk("busy",       32'(busy),       32'(eb_a[cyc]));
            chk("Data_Valid", 32'(Data_Valid), 32'(edv_a[cyc]));
            chk("par_err",    32'(par_err),    32'(epe_a[cyc]));
            chk("stp_err",    32'(stp_err),    32'(ese_a[cyc]));
            chk("P_DATA",     32'(P_DATA),     32'(epd_a[cyc]));
            foreach (lits[j]) begin
                if (lits[j].cyc == cyc) chk(sig_name(lits[j].sig), sig_val(lits[j].sig), 32'(lits[j].val));
            end
        end
    end

    initial begin
        int s1, s2, s2b, s3, s4, s5, s6, s7, s8, sd;
        int p;
        logic [FW-1:0] d;
        RST = 1'b1; RX_IN = 1'b1; Prescale = PW'(8); PAR_EN = 1'b0; PAR_TYP = 1'b0;

        reset_cycles(4);
        lits.push_back('{2, 0, 0});
        lits.push_back('{2, 4, 0});
        idle(3);

        send_frame(8, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b1, -1, -1, s1);
        idle(5);
        lits.push_back('{s1 + 88, 1, 1});
        lits.push_back('{s1 + 88, 0, 8'hA5});
        lits.push_back('{s1 + 87, 4, 1});
        lits.push_back('{s1 + 88, 4, 0});

        send_frame(16, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, -1, -1, s2);
        send_frame(16, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, -1, -1, s2b);
        idle(4);
        lits.push_back('{s2 + 160, 1, 1});
        lits.push_back('{s2 + 160, 0, 8'h00});
        lits.push_back('{s2 + 320, 1, 1});
        lits.push_back('{s2 + 320, 0, 8'hFF});

        glitch(8, 3, s3);
        idle(3);
        lits.push_back('{s3 + 5, 4, 1});
        lits.push_back('{s3 + 6, 4, 0});

        send_frame(8, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b1, -1, -1, s4);
        idle(3);
        lits.push_back('{s4 + 88, 2, 1});
        lits.push_back('{s4 + 88, 1, 0});
        lits.push_back('{s4 + 88, 0, 8'hFF});

        send_frame(32, 1'b0, 1'b0, 8'h96, 1'b0, 1'b0, -1, -1, s5);
        idle(3);
        lits.push_back('{s5 + 320, 3, 1});
        lits.push_back('{s5 + 320, 0, 8'hFF});

        send_frame(32, 1'b0, 1'b0, 8'h4B, 1'b0, 1'b1, 3 * 32 + 15, -1, s6);
        idle(3);
        lits.push_back('{s6 + 320, 1, 1});
        lits.push_back('{s6 + 320, 0, 8'h4B});

        send_frame(8, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b1, -1, 5 * 8 + 4, s7);
        reset_cycles(2);
        idle(3);
        lits.push_back('{s7 + 44, 0, 0});
        lits.push_back('{s7 + 44, 4, 0});
        send_frame(8, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1, -1, -1, s8);
        idle(3);
        lits.push_back('{s8 + 80, 1, 1});
        lits.push_back('{s8 + 80, 0, 8'h5A});

        for (int n = 0; n < 30; n++) begin
            p = 8 + 2 * int'($urandom_range(0, 12));
            d = FW'($urandom);
            if ($urandom_range(0, 5) == 0) begin
                glitch(p, int'($urandom_range(1, p / 2)), sd);
            end else begin
                send_frame(p, 1'($urandom), 1'($urandom), d,
                           $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
                           -1, -1, sd);
            end
            idle(int'($urandom_range(0, 4)));
        end
        idle(4);

        for (int i = 0; i < cur; i++) begin
            @(negedge CLK);
            cyc      = i;
            RST      = rst_a[i];
            RX_IN    = rx_a[i];
            Prescale = ps_a[i];
            PAR_EN   = pen_a[i];
            PAR_TYP  = pt_a[i];
        end
        @(negedge CLK);
        cyc = -1;
        #5;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
